// File: rtl/imem_loader_if.sv
// Wishbone classic slave bundle for the jacaranda-8 instruction-memory loader.
interface imem_loader_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/imem_loader.sv
// Loader/run controller for jacaranda-8: streams firmware into instruction memory while halted.
// Optional IMEM_READBACK_EN: DATA reads return imem[PTR] with a 3-cycle ack and advance PTR.
module imem_loader #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    imem_loader_if.slave  wb,
    input  logic          halt_req_i,
    input  logic [7:0]    cpu_pc,
    input  logic [7:0]    imem_rdata,
    output logic [7:0]    imem_addr,
    output logic [7:0]    imem_wdata,
    output logic          imem_we,
    output logic          cpu_rst_n_o
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PTR    = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        run_r;
    logic        run_nxt_s;
    logic [7:0]  ptr_r;
    logic [7:0]  addr_q_r;
    logic        err_r;
    logic [8:0]  count_r;
    logic        ack_r;
    logic [31:0] dat_r;
    logic        we_r;
    logic [7:0]  wdata_r;
    logic        cpu_rst_n_r;
    logic        rd_a_r;
    logic        rd_b_r;
    logic        hit_s;
    logic        req_s;
    logic        ctrl_wr_s;
    logic [1:0]  reg_s;
    logic [31:0] status_s;
    logic        unused_s;

    assign wb.wbs_ack_o = ack_r;
    assign wb.wbs_dat_o = dat_r;
    assign imem_we      = we_r;
    assign imem_wdata   = wdata_r;
    assign cpu_rst_n_o  = cpu_rst_n_r;
    assign unused_s     = ^{wb.wbs_adr_i[1:0], wb.wbs_sel_i[3:1], wb.wbs_dat_i[31:8]};

    // Request decode; a pending readback blocks re-acceptance like the ack cycle does.
    always_comb begin
        reg_s     = wb.wbs_adr_i[3:2];
        hit_s     = (wb.wbs_adr_i[31:4] == BASE_ADR[31:4]);
        req_s     = wb.wbs_stb_i & wb.wbs_cyc_i & hit_s & ~ack_r & ~rd_a_r & ~rd_b_r;
        ctrl_wr_s = req_s & wb.wbs_we_i & wb.wbs_sel_i[0] & (reg_s == REG_CTRL);
        status_s  = {7'h00, count_r, 14'h0000, err_r, (state_r == ST_RUN)};
        imem_addr = (state_r == ST_HALT) ? addr_q_r : cpu_pc;
        if (halt_req_i) begin
            run_nxt_s = 1'b0;
        end else if (ctrl_wr_s) begin
            run_nxt_s = wb.wbs_dat_i[0];
        end else begin
            run_nxt_s = run_r;
        end
    end

    // Run FSM next state, driven by the post-update RUN bit so START follows the accepting edge.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_HALT: begin
                if (run_nxt_s) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            ST_START: begin
                if (run_nxt_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            ST_RUN: begin
                if (run_nxt_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: state_nxt_s = ST_HALT;
        endcase
    end

    // FSM state and registered CPU reset release.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r     <= ST_HALT;
            run_r       <= 1'b0;
            cpu_rst_n_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            run_r       <= run_nxt_s;
            cpu_rst_n_r <= (state_nxt_s == ST_RUN);
        end
    end

    // Register file, bus response and memory write port.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ptr_r    <= 8'h00;
            addr_q_r <= 8'h00;
            err_r    <= 1'b0;
            count_r  <= 9'h000;
            ack_r    <= 1'b0;
            dat_r    <= 32'h0000_0000;
            we_r     <= 1'b0;
            wdata_r  <= 8'h00;
            rd_a_r   <= 1'b0;
            rd_b_r   <= 1'b0;
        end else begin
            ack_r  <= 1'b0;
            dat_r  <= 32'h0000_0000;
            we_r   <= 1'b0;
            rd_a_r <= 1'b0;
            rd_b_r <= rd_a_r;
            if (rd_b_r) begin
                ack_r <= 1'b1;
                dat_r <= {24'h000000, imem_rdata};
                ptr_r <= ptr_r + 8'h01;
            end
            if (req_s) begin
                ack_r <= 1'b1;
                case (reg_s)
                    REG_CTRL: begin
                        dat_r <= {31'h0000_0000, run_r};
                        if (ctrl_wr_s && wb.wbs_dat_i[1]) begin
                            ptr_r   <= 8'h00;
                            count_r <= 9'h000;
                        end
                    end
                    REG_PTR: begin
                        dat_r <= {24'h000000, ptr_r};
                        if (wb.wbs_we_i && wb.wbs_sel_i[0]) begin
                            ptr_r <= wb.wbs_dat_i[7:0];
                        end
                    end
                    REG_DATA: begin
                        addr_q_r <= ptr_r;
                        if (wb.wbs_we_i) begin
                            if (state_r != ST_HALT) begin
                                err_r <= 1'b1;
                            end else if (wb.wbs_sel_i[0]) begin
                                we_r    <= 1'b1;
                                wdata_r <= wb.wbs_dat_i[7:0];
                                ptr_r   <= ptr_r + 8'h01;
                                if (count_r != 9'h100) begin
                                    count_r <= count_r + 9'h001;
                                end
                            end
                        end else begin
`ifdef IMEM_READBACK_EN
                            if (state_r == ST_HALT) begin
                                ack_r  <= 1'b0;
                                rd_a_r <= 1'b1;
                            end else begin
                                err_r <= 1'b1;
                            end
`endif
                        end
                    end
                    REG_STATUS: begin
                        dat_r <= status_s;
                        if (wb.wbs_we_i && wb.wbs_sel_i[0] && wb.wbs_dat_i[1]) begin
                            err_r <= 1'b0;
                        end
                    end
                    default: dat_r <= 32'h0000_0000;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader with a behavioural 256x8 synchronous memory.
module tb_imem_loader;

    localparam logic [31:0] A_CTRL = 32'h3000_0000;
    localparam logic [31:0] A_PTR  = 32'h3000_0004;
    localparam logic [31:0] A_DATA = 32'h3000_0008;
    localparam logic [31:0] A_STAT = 32'h3000_000C;
    localparam logic [31:0] A_MISS = 32'h3000_0010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       halt_req;
    logic [7:0] cpu_pc;
    logic [7:0] imem_rdata;
    logic [7:0] imem_addr;
    logic [7:0] imem_wdata;
    logic       imem_we;
    logic       cpu_rst_n;
    logic [7:0] mem [256];

    int checks = 0;
    int errors = 0;

    logic        cap_ack;
    logic [31:0] cap_dat;
    logic        cap_we;
    logic [7:0]  cap_wdata;
    logic [7:0]  cap_addr;
    logic        cap_rstn;
    logic        cap2_rstn;
    logic        cap2_we;

    imem_loader_if wb ();

    imem_loader dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .wb          (wb),
        .halt_req_i  (halt_req),
        .cpu_pc      (cpu_pc),
        .imem_rdata  (imem_rdata),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .imem_we     (imem_we),
        .cpu_rst_n_o (cpu_rst_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_we) mem[imem_addr] <= imem_wdata;
        imem_rdata <= mem[imem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request held over the accepting edge, then one idle cycle; samples #1 after each edge.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wb.wbs_stb_i = 1'b1;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_we_i  = w;
        wb.wbs_adr_i = a;
        wb.wbs_dat_i = d;
        wb.wbs_sel_i = s;
        @(posedge clk); #1;
        cap_ack   = wb.wbs_ack_o;
        cap_dat   = wb.wbs_dat_o;
        cap_we    = imem_we;
        cap_wdata = imem_wdata;
        cap_addr  = imem_addr;
        cap_rstn  = cpu_rst_n;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        @(posedge clk); #1;
        cap2_rstn = cpu_rst_n;
        cap2_we   = imem_we;
    endtask

    task automatic data_write(input logic [7:0] b, input logic [7:0] exp_addr, input string tag);
        access(1'b1, A_DATA, {24'h000000, b}, 4'hF);
        check({tag, "_ack"}, {31'h0, cap_ack}, 32'h1);
        check({tag, "_we"}, {31'h0, cap_we}, 32'h1);
        check({tag, "_wdata"}, {24'h0, cap_wdata}, {24'h0, b});
        check({tag, "_addr"}, {24'h0, cap_addr}, {24'h0, exp_addr});
        check({tag, "_we_drop"}, {31'h0, cap2_we}, 32'h0);
    endtask

    task automatic read_reg(input logic [31:0] a, input logic [31:0] exp, input string tag);
        access(1'b0, a, 32'h0, 4'hF);
        check({tag, "_ack"}, {31'h0, cap_ack}, 32'h1);
        check(tag, cap_dat, exp);
    endtask

    initial begin
        rst_n = 1'b1;
        halt_req = 1'b0;
        cpu_pc = 8'h00;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'h0;
        wb.wbs_adr_i = 32'h0;
        wb.wbs_dat_i = 32'h0;
        #2 rst_n = 1'b0;
        #20;
        check("rst_ack", {31'h0, wb.wbs_ack_o}, 32'h0);
        check("rst_dat", wb.wbs_dat_o, 32'h0);
        check("rst_we", {31'h0, imem_we}, 32'h0);
        check("rst_wdata", {24'h0, imem_wdata}, 32'h0);
        check("rst_addr", {24'h0, imem_addr}, 32'h0);
        check("rst_cpu_rst_n", {31'h0, cpu_rst_n}, 32'h0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        read_reg(A_STAT, 32'h0000_0000, "status_reset");
        access(1'b1, A_CTRL, 32'h2, 4'hF);
        check("clr_ack", {31'h0, cap_ack}, 32'h1);
        data_write(8'hA1, 8'h00, "wr0");
        data_write(8'hB2, 8'h01, "wr1");
        data_write(8'hC3, 8'h02, "wr2");
        read_reg(A_PTR, 32'h0000_0003, "ptr_after3");
        read_reg(A_STAT, 32'h0003_0000, "count3");
        check("mem1", {24'h0, mem[1]}, 32'hB2);

        // Pointer wrap 0xFF -> 0x00
        access(1'b1, A_PTR, 32'hFF, 4'h1);
        data_write(8'h11, 8'hFF, "wrFF");
        data_write(8'h22, 8'h00, "wr00");
        read_reg(A_PTR, 32'h0000_0001, "ptr_wrap");
        check("memFF", {24'h0, mem[8'hFF]}, 32'h11);
        check("mem00", {24'h0, mem[0]}, 32'h22);

        // sel[0]=0 in HALT: acked, no write, pointer kept
        access(1'b1, A_DATA, 32'h55, 4'hE);
        check("sel0_ack", {31'h0, cap_ack}, 32'h1);
        check("sel0_we", {31'h0, cap_we}, 32'h0);
        read_reg(A_PTR, 32'h0000_0001, "sel0_ptr");

`ifndef IMEM_READBACK_EN
        read_reg(A_DATA, 32'h0000_0000, "data_read0");
`endif

        // Start the CPU: START after N, RUN after N+1
        cpu_pc = 8'h42;
        access(1'b1, A_CTRL, 32'h1, 4'h1);
        check("start_rstn_N", {31'h0, cap_rstn}, 32'h0);
        check("start_rstn_N1", {31'h0, cap2_rstn}, 32'h1);
        check("start_addr_pc", {24'h0, cap_addr}, 32'h42);
        cpu_pc = 8'h17;
        #1;
        check("run_addr_pc", {24'h0, imem_addr}, 32'h17);

        access(1'b1, A_DATA, 32'h77, 4'hF);
        check("run_wr_ack", {31'h0, cap_ack}, 32'h1);
        check("run_wr_we", {31'h0, cap_we}, 32'h0);
        read_reg(A_STAT, 32'h0005_0003, "run_status_err");
        read_reg(A_PTR, 32'h0000_0001, "run_ptr");
        access(1'b1, A_STAT, 32'h2, 4'h1);
        read_reg(A_STAT, 32'h0005_0001, "err_cleared");

        // halt_req wins over a same-cycle RUN write
        halt_req = 1'b1;
        access(1'b1, A_CTRL, 32'h1, 4'h1);
        check("halt_rstn", {31'h0, cap_rstn}, 32'h0);
        halt_req = 1'b0;
        read_reg(A_CTRL, 32'h0000_0000, "halt_ctrl");
        read_reg(A_STAT, 32'h0005_0000, "halt_status");
        access(1'b1, A_CTRL, 32'h2, 4'h1);
        read_reg(A_STAT, 32'h0000_0000, "clr_status");

        // Async reset during a DATA ack cycle
        access(1'b1, A_PTR, 32'h10, 4'h1);
        wb.wbs_stb_i = 1'b1;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_we_i  = 1'b1;
        wb.wbs_adr_i = A_DATA;
        wb.wbs_dat_i = 32'h33;
        wb.wbs_sel_i = 4'h1;
        @(posedge clk); #1;
        check("mid_we", {31'h0, imem_we}, 32'h1);
        check("mid_addr", {24'h0, imem_addr}, 32'h10);
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack", {31'h0, wb.wbs_ack_o}, 32'h0);
        check("mid_rst_we", {31'h0, imem_we}, 32'h0);
        check("mid_rst_addr", {24'h0, imem_addr}, 32'h0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        read_reg(A_PTR, 32'h0000_0000, "mid_rst_ptr");
        read_reg(A_STAT, 32'h0000_0000, "mid_rst_status");

        // Out-of-range address gets no ack
        access(1'b0, A_MISS, 32'h0, 4'hF);
        check("miss_ack", {31'h0, cap_ack}, 32'h0);

`ifdef IMEM_READBACK_EN
        access(1'b1, A_PTR, 32'h04, 4'h1);
        data_write(8'h5A, 8'h04, "rb_load");
        access(1'b1, A_PTR, 32'h04, 4'h1);
        wb.wbs_stb_i = 1'b1;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_adr_i = A_DATA;
        wb.wbs_sel_i = 4'h1;
        @(posedge clk); #1;
        check("rb_ack_N", {31'h0, wb.wbs_ack_o}, 32'h0);
        @(posedge clk); #1;
        check("rb_ack_N1", {31'h0, wb.wbs_ack_o}, 32'h0);
        @(posedge clk); #1;
        check("rb_ack_N2", {31'h0, wb.wbs_ack_o}, 32'h1);
        check("rb_dat", wb.wbs_dat_o, 32'h0000_005A);
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        @(posedge clk); #1;
        read_reg(A_PTR, 32'h0000_0005, "rb_ptr");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
